// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional leading-zero blanking output when BIN2BCD_LEAD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
`ifdef BIN2BCD_LEAD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr, corr, sr_shift;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_acc, ovf_now;
  logic              load, step, last;

  // All digit fields corrected in parallel; +3 on a value of 5..9 stays within the nibble.
  always_comb begin
    corr = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W + 4*d +: 4] >= 4'd5)
        corr[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
    end
  end

  assign sr_shift = {corr[SR_W-2:0], 1'b0};
  assign ovf_now  = ovf_acc | corr[SR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      sr      <= {{BCD_W{1'b0}}, bin_in};
      cnt     <= CNT_W'(BIN_W);
      ovf_acc <= 1'b0;
    end else if (step) begin
      sr      <= sr_shift;
      cnt     <= cnt - CNT_W'(1);
      ovf_acc <= ovf_now;
      if (last) begin
        bcd_out <= sr_shift[SR_W-1 -: BCD_W];
        ovf     <= ovf_now;
      end
    end
  end

`ifdef BIN2BCD_LEAD_BLANK_EN
  logic [DIGITS-1:0] blank_nx;
  logic              zero_run;

  // Walk from the top digit down; digit 0 is never blanked.
  always_comb begin
    blank_nx = '0;
    zero_run = 1'b1;
    for (int unsigned d = DIGITS - 1; d >= 1; d--) begin
      zero_run    = zero_run && (sr_shift[BIN_W + 4*d +: 4] == 4'd0);
      blank_nx[d] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          blank <= '0;
    else if (step && last) blank <= blank_nx;
  end
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Generalises the fixed 4-bit digit-correction adder to BIN_W input bits and DIGITS output digits.
- Adds a start/busy/done handshake and overflow detection.
- Sits between the multiplier/ALU result and the BCD display driver in the calculator datapath.

Parameters:
- BIN_W, 8, width of the unsigned binary input (>= 2).
- DIGITS, 3, number of BCD output digits (>= 1). A result that does not fit sets ovf; it is not an error.
- CNT_W, $clog2(BIN_W+1), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only when the FSM is IDLE or DONE.
- bin_in  input  BIN_W  unsigned operand; captured on the accepted start edge only.
- busy  output  1  high while the conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse; bcd_out and ovf are valid from this cycle.
- bcd_out  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; holds its value until the next done.
- ovf  output  1  result exceeded 10^DIGITS-1; valid with done and held like bcd_out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, bcd_out=0, ovf=0; internal shift register and counter cleared.
  - Reset asserted mid-conversion aborts it; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 -> load shift register with {DIGITS*4 zeros, bin_in}, cnt=BIN_W, ovf_acc=0, go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - (a) add 3 to every BCD digit field whose value is >= 5; all digits are corrected in parallel, combinationally.
  - (b) shift the whole register left by 1.
  - (c) if the bit leaving the top of the BCD field is 1, set ovf_acc.
  - (d) decrement cnt.
  - When cnt==1 at the start of the cycle (last shift), go to DONE. On that edge, load bcd_out with the post-shift BCD field and load ovf with ovf_acc, including any overflow from this final shift.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - start=0 -> IDLE.
  - start=1 -> accepted back-to-back: capture bin_in and go to SHIFT, exactly as from IDLE. done still pulses this cycle.
- Latency: start sampled at edge k -> busy high for cycles k+1..k+BIN_W -> done high in cycle k+BIN_W+1. Throughput is one conversion per BIN_W+1 cycles.
- start while in SHIFT is ignored. bin_in is not re-sampled, and the in-flight result is unaffected.
- bin_in changes outside the accepted start edge have no effect.
- Digit correction is computed modulo 16 inside each 4-bit field. A value >= 5 plus 3 never exceeds 12, so no carry crosses between digit fields during correction.
- On overflow, bcd_out holds the low DIGITS digits of the true decimal value, each digit valid 0–9, and ovf=1.
- bcd_out and ovf change only on the edge entering DONE.

Optional Feature:
- Macro: BIN2BCD_LEAD_BLANK_EN.
- Defined:
  - Adds output port blank[DIGITS-1:0].
  - blank[i]=1 when digit i and every higher digit are 0, with i < DIGITS-1 … 0 evaluated top-down. Digit 0 is never blanked.
  - Registered and updated on the same edge as bcd_out; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. BIN_W=8, DIGITS=3, bin_in=8'd255, start pulse at edge k -> busy high k+1..k+8; done only in cycle k+9; bcd_out=12'h255; ovf=0.
2. bin_in=0 -> bcd_out=12'h000, ovf=0. bin_in=99 -> 12'h099. bin_in=100 -> 12'h100, ovf=0.
3. bin_in=37 accepted; start=1 with bin_in=200 at cycle k+3 -> ignored, result 12'h037. Then start asserted in the DONE cycle with bin_in=200 -> busy next cycle, second done gives 12'h200.
4. rst_n low at cycle k+4 of a conversion of 255 -> outputs 0 immediately, no done. After release, start with bin_in=42 -> 12'h042.
5. BIN_W=8, DIGITS=2, bin_in=200 -> bcd_out=8'h00, ovf=1. bin_in=99 -> 8'h99, ovf=0. BIN_W=10, DIGITS=4, bin_in=1023 -> 16'h1023.
6. With BIN2BCD_LEAD_BLANK_EN, DIGITS=3: bin_in=7 -> blank=3'b110; bin_in=0 -> blank=3'b110; bin_in=105 -> blank=3'b000.
